// File: rtl/stack_ptr_unit_pkg.sv
// stack_ptr_unit_pkg: shared defaults and helpers for the bounded stack pointer
//   SPU_BITS_DEF : default pointer width when the top-level width macro is absent
//   in_range()   : inclusive range test used for load validation
package stack_ptr_unit_pkg;

   localparam int SPU_BITS_DEF = 8;

   function automatic logic in_range(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/stack_ptr_unit_sp_next_calc.sv
// stack_ptr_unit_sp_next_calc: combinational next-pointer and error-event strobes
//   i_sp          in   BITS  current pointer
//   i_push        in   1     increment request
//   i_pop         in   1     decrement request
//   i_load        in   1     load request (highest priority)
//   i_load_value  in   BITS  value for load
//   o_sp_next     out  BITS  pointer value for the next edge
//   o_ovf_ev      out  1     push attempted at LIMIT this cycle
//   o_unf_ev      out  1     pop attempted at BASE this cycle
//   o_bad_ev      out  1     load value outside [BASE, LIMIT] this cycle
module stack_ptr_unit_sp_next_calc
   import stack_ptr_unit_pkg::*;
#(
   parameter int BITS  = SPU_BITS_DEF,
   parameter int BASE  = 0,
   parameter int LIMIT = 255,
   parameter bit WRAP  = 1'b1
) (
   input  logic [BITS-1:0] i_sp,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic            i_load,
   input  logic [BITS-1:0] i_load_value,
   output logic [BITS-1:0] o_sp_next,
   output logic            o_ovf_ev,
   output logic            o_unf_ev,
   output logic            o_bad_ev
);

   localparam logic [BITS-1:0] L_BASE  = BITS'(BASE);
   localparam logic [BITS-1:0] L_LIMIT = BITS'(LIMIT);

   logic            w_inc;
   logic            w_dec;
   logic            w_at_base;
   logic            w_at_lim;
   logic            w_ok;
   logic [BITS-1:0] w_inc_val;
   logic [BITS-1:0] w_dec_val;

   // push and pop together cancel; load masks both so they raise no events
   assign w_inc     = ~i_load & i_push & ~i_pop;
   assign w_dec     = ~i_load & i_pop & ~i_push;
   assign w_at_base = (i_sp == L_BASE);
   assign w_at_lim  = (i_sp == L_LIMIT);
   assign w_ok      = in_range(int'({1'b0, i_load_value}), BASE, LIMIT);

   assign w_inc_val = w_at_lim  ? (WRAP ? L_BASE  : i_sp) : i_sp + 1'b1;
   assign w_dec_val = w_at_base ? (WRAP ? L_LIMIT : i_sp) : i_sp - 1'b1;

   assign o_sp_next = i_load ? (w_ok ? i_load_value : i_sp) :
                      w_inc  ? w_inc_val :
                      w_dec  ? w_dec_val : i_sp;

   assign o_ovf_ev = w_inc & w_at_lim;
   assign o_unf_ev = w_dec & w_at_base;
   assign o_bad_ev = i_load & ~w_ok;

endmodule

// File: rtl/stack_ptr_unit.sv
// stack_ptr_unit: bounded stack pointer over [BASE, LIMIT] with sticky error flags
//   clk           in   1     clock, rising edge
//   rst_n         in   1     asynchronous active-low reset
//   i_push        in   1     increment request
//   i_pop         in   1     decrement request
//   i_load        in   1     load i_load_value into sp
//   i_load_value  in   BITS  value for load
//   i_clear_err   in   1     clears sticky flags (a same-cycle event still sets its flag)
//   o_sp          out  BITS  registered stack pointer
//   o_empty       out  1     sp == BASE
//   o_full        out  1     sp == LIMIT
//   o_overflow    out  1     sticky: push while full
//   o_underflow   out  1     sticky: pop while empty
//   o_bad_load    out  1     sticky: load value out of range
module stack_ptr_unit
   import stack_ptr_unit_pkg::*;
#(
   parameter int BITS  = SPU_BITS_DEF,
   parameter int BASE  = 0,
   parameter int LIMIT = 255,
   parameter bit WRAP  = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic            i_load,
   input  logic [BITS-1:0] i_load_value,
   input  logic            i_clear_err,
   output logic [BITS-1:0] o_sp,
   output logic            o_empty,
   output logic            o_full,
   output logic            o_overflow,
   output logic            o_underflow,
   output logic            o_bad_load
);

   localparam logic [BITS-1:0] L_BASE  = BITS'(BASE);
   localparam logic [BITS-1:0] L_LIMIT = BITS'(LIMIT);

   logic [BITS-1:0] r_sp;
   logic            r_ovf;
   logic            r_unf;
   logic            r_bad;
   logic [BITS-1:0] w_sp_next;
   logic            w_ovf_ev;
   logic            w_unf_ev;
   logic            w_bad_ev;

   stack_ptr_unit_sp_next_calc #(
      .BITS  (BITS),
      .BASE  (BASE),
      .LIMIT (LIMIT),
      .WRAP  (WRAP)
   ) u_next (
      .i_sp         (r_sp),
      .i_push       (i_push),
      .i_pop        (i_pop),
      .i_load       (i_load),
      .i_load_value (i_load_value),
      .o_sp_next    (w_sp_next),
      .o_ovf_ev     (w_ovf_ev),
      .o_unf_ev     (w_unf_ev),
      .o_bad_ev     (w_bad_ev)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sp  <= L_BASE;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         r_bad <= 1'b0;
      end else begin
         r_sp  <= w_sp_next;
         // new event overrides a same-cycle clear
         r_ovf <= w_ovf_ev | (r_ovf & ~i_clear_err);
         r_unf <= w_unf_ev | (r_unf & ~i_clear_err);
         r_bad <= w_bad_ev | (r_bad & ~i_clear_err);
      end

   assign o_sp        = r_sp;
   assign o_empty     = (r_sp == L_BASE);
   assign o_full      = (r_sp == L_LIMIT);
   assign o_overflow  = r_ovf;
   assign o_underflow = r_unf;
   assign o_bad_load  = r_bad;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// tb_stack_ptr_unit: table-driven scoreboard bench for three stack_ptr_unit configurations
module tb_stack_ptr_unit;

   typedef struct packed {
      logic [2:0] ctl;
      logic [7:0] lv;
      logic       clr;
      logic [7:0] sp;
      logic [4:0] fl;
   } vec_t;

   typedef struct {
      int          d;
      logic [12:0] val;
      string       nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_push = 1'b0;
   logic       i_pop = 1'b0;
   logic       i_load = 1'b0;
   logic [7:0] i_load_value = 8'h00;
   logic       i_clear_err = 1'b0;

   logic [7:0] sp0, sp1, sp2;
   logic       e0, e1, e2, f0, f1, f2, o0, o1, o2, u0, u1, u2, b0, b1, b2;

   int   pass = 0;
   int   total = 0;
   exp_t q[$];
   vec_t tw[$];
   vec_t ts[$];

   always #5 clk = ~clk;

   stack_ptr_unit #(.BITS(8), .BASE(16), .LIMIT(19), .WRAP(1'b1)) u_wrap (
      .clk(clk), .rst_n(rst_n), .i_push(i_push), .i_pop(i_pop), .i_load(i_load),
      .i_load_value(i_load_value), .i_clear_err(i_clear_err), .o_sp(sp0), .o_empty(e0),
      .o_full(f0), .o_overflow(o0), .o_underflow(u0), .o_bad_load(b0));

   stack_ptr_unit #(.BITS(8), .BASE(16), .LIMIT(19), .WRAP(1'b0)) u_sat (
      .clk(clk), .rst_n(rst_n), .i_push(i_push), .i_pop(i_pop), .i_load(i_load),
      .i_load_value(i_load_value), .i_clear_err(i_clear_err), .o_sp(sp1), .o_empty(e1),
      .o_full(f1), .o_overflow(o1), .o_underflow(u1), .o_bad_load(b1));

   stack_ptr_unit u_leg (
      .clk(clk), .rst_n(rst_n), .i_push(i_push), .i_pop(i_pop), .i_load(i_load),
      .i_load_value(i_load_value), .i_clear_err(i_clear_err), .o_sp(sp2), .o_empty(e2),
      .o_full(f2), .o_overflow(o2), .o_underflow(u2), .o_bad_load(b2));

   function automatic vec_t mk(input logic [2:0] ctl, input logic [7:0] lv, input logic clr,
                               input logic [7:0] sp, input logic [4:0] fl);
      vec_t v;
      v.ctl = ctl;
      v.lv  = lv;
      v.clr = clr;
      v.sp  = sp;
      v.fl  = fl;
      return v;
   endfunction

   function automatic logic [12:0] obs(input int d);
      return d == 0 ? {sp0, e0, f0, o0, u0, b0} :
             d == 1 ? {sp1, e1, f1, o1, u1, b1} : {sp2, e2, f2, o2, u2, b2};
   endfunction

   task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
      total++;
      if (act[12:5] !== exp[12:5]) $display("FAIL %s sp got=%h want=%h", nm, act[12:5], exp[12:5]);
      else pass++;
      total++;
      if (act[4:0] !== exp[4:0])
         $display("FAIL %s flags{e,f,ovf,unf,bad} got=%b want=%b", nm, act[4:0], exp[4:0]);
      else pass++;
   endtask

   task automatic step(input int d, input vec_t v, input string nm);
      exp_t e;
      @(negedge clk);
      {i_push, i_pop, i_load} = v.ctl;
      i_load_value = v.lv;
      i_clear_err  = v.clr;
      q.push_back('{d, {v.sp, v.fl}, nm});
      @(posedge clk);
      #1;
      {i_push, i_pop, i_load} = 3'b000;
      i_clear_err = 1'b0;
      total++;
      if (q.size() == 0) $display("FAIL %s scoreboard empty got=0 want=1", nm);
      else begin
         pass++;
         e = q.pop_front();
         chk(e.nm, obs(e.d), e.val);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tw.push_back(mk(3'b100, 8'h00, 1'b0, 8'h11, 5'b00000));
      tw.push_back(mk(3'b100, 8'h00, 1'b0, 8'h12, 5'b00000));
      tw.push_back(mk(3'b100, 8'h00, 1'b0, 8'h13, 5'b01000));
      tw.push_back(mk(3'b100, 8'h00, 1'b0, 8'h10, 5'b10100));
      tw.push_back(mk(3'b010, 8'h00, 1'b0, 8'h13, 5'b01110));
      tw.push_back(mk(3'b000, 8'h00, 1'b1, 8'h13, 5'b01000));
      tw.push_back(mk(3'b010, 8'h00, 1'b0, 8'h12, 5'b00000));
      tw.push_back(mk(3'b010, 8'h00, 1'b0, 8'h11, 5'b00000));
      tw.push_back(mk(3'b110, 8'h00, 1'b0, 8'h11, 5'b00000));
      tw.push_back(mk(3'b101, 8'h13, 1'b0, 8'h13, 5'b01000));
      tw.push_back(mk(3'b001, 8'h20, 1'b0, 8'h13, 5'b01001));
      tw.push_back(mk(3'b001, 8'h05, 1'b1, 8'h13, 5'b01001));
      tw.push_back(mk(3'b000, 8'h00, 1'b1, 8'h13, 5'b01000));
      tw.push_back(mk(3'b011, 8'h10, 1'b0, 8'h10, 5'b10000));
      tw.push_back(mk(3'b001, 8'h0F, 1'b0, 8'h10, 5'b10001));
      tw.push_back(mk(3'b010, 8'h00, 1'b1, 8'h13, 5'b01010));
      tw.push_back(mk(3'b001, 8'h12, 1'b0, 8'h12, 5'b00010));

      ts.push_back(mk(3'b010, 8'h00, 1'b0, 8'h10, 5'b10010));
      ts.push_back(mk(3'b000, 8'h00, 1'b1, 8'h10, 5'b10000));
      ts.push_back(mk(3'b100, 8'h00, 1'b0, 8'h11, 5'b00000));
      ts.push_back(mk(3'b100, 8'h00, 1'b0, 8'h12, 5'b00000));
      ts.push_back(mk(3'b100, 8'h00, 1'b0, 8'h13, 5'b01000));
      ts.push_back(mk(3'b100, 8'h00, 1'b0, 8'h13, 5'b01100));
      ts.push_back(mk(3'b100, 8'h00, 1'b1, 8'h13, 5'b01100));
      ts.push_back(mk(3'b001, 8'h10, 1'b0, 8'h10, 5'b10100));
      ts.push_back(mk(3'b010, 8'h00, 1'b0, 8'h10, 5'b10110));
      ts.push_back(mk(3'b000, 8'h00, 1'b1, 8'h10, 5'b10000));

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_wrap", obs(0), {8'h10, 5'b10000});
      chk("reset_sat", obs(1), {8'h10, 5'b10000});
      chk("reset_leg", obs(2), {8'h00, 5'b10000});

      step(0, tw[0], "pre_rst_push1");
      step(0, tw[1], "pre_rst_push2");
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_wrap", obs(0), {8'h10, 5'b10000});
      chk("async_rst_leg", obs(2), {8'h00, 5'b10000});
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tw[i]) step(0, tw[i], $sformatf("wrap_vec%0d", i));

      do_reset();
      foreach (ts[i]) step(1, ts[i], $sformatf("sat_vec%0d", i));

      do_reset();
      for (int i = 1; i <= 255; i++)
         step(2, mk(3'b100, 8'h00, 1'b0, 8'(i), {1'b0, i == 255, 3'b000}), $sformatf("leg_up%0d", i));
      step(2, mk(3'b100, 8'h00, 1'b0, 8'h00, 5'b10100), "leg_wrap_push");
      step(2, mk(3'b010, 8'h00, 1'b0, 8'hFF, 5'b01110), "leg_wrap_pop");
      step(2, mk(3'b000, 8'h00, 1'b1, 8'hFF, 5'b01000), "leg_clr");
      for (int i = 254; i >= 0; i--)
         step(2, mk(3'b010, 8'h00, 1'b0, 8'(i), {i == 0, 4'b0000}), $sformatf("leg_down%0d", i));

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
